stage_fetch_buf: RTL and testbench
==================================

Name: stage_fetch_buf

Overview:
- Two-entry-deep (parameterisable) instruction skid buffer sitting directly downstream of the fetch stage and feeding decode.
- Captures {pc, instr} pairs produced by fetch using a valid/ready handshake.
- Decouples decode stalls from the fetch PC register, and discards in-flight instructions on a control-flow redirect (flush).

Parameters:
- DEPTH, 2, number of buffered entries; power of two, ≥2.
- NOP_INSTR, 32'h0000_0000, instruction word driven on out_instr when the buffer is empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (buffer reset when sampled 0 at posedge clk).
- flush  input  1  redirect; discard all buffered entries and any same-cycle push.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  buffer can accept this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: circular array of DEPTH × {pc[31:0], instr[31:0]}; rd_ptr, wr_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracked separately.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH), combinational from state only; no dependence on out_ready. A full buffer refuses a push even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_pc = head pc when valid, else 32'h0. out_instr = head instr when valid, else NOP_INSTR.
- Latency: a pushed entry appears on out_* the cycle after the push edge. No combinational in→out bypass.
- Push only: write at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (count in 1..DEPTH-1): both pointers advance, count unchanged.
- Empty with push and out_ready=1: push only, because out_valid=0.
- flush=1 (reset high): rd_ptr=wr_ptr=0, count=0, at next edge. Same-cycle push and pop are suppressed. in_ready still reflects pre-flush count that cycle.
- Delay slot: flush discards everything. Whoever asserts flush guarantees the delay-slot instruction has already been popped or is re-presented by fetch.
- Reset (reset=0 at posedge): pointers and count 0, outputs settle to the empty values above. Reset overrides flush and handshakes; a mid-stream reset drops all entries.
- Storage contents are not reset. Outputs never expose stale entries because of the count gating.

Optional Feature:
- Macro FETCH_BUF_STALL_CNT_EN.
- Defined: extra port stall_cnt output 32.
  - Increments on every cycle with reset=1, in_valid=1 and in_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: port and counter absent; everything else identical.

Decomposition:
- def.v (shared):
  - `NOP_INSTR value (32'h0).
  - `PC_RESET value (32'h0000_3000), used by benches for expected PCs.
  - Width macros for pc/instr.
- One sub-module, fetch_buf_ptr: wrapping pointer register.
  - Inputs: clk, reset, clear, inc.
  - Output: ptr.
  - Instantiated twice, for rd_ptr and wr_ptr.

Test Plan:
- Reset then idle: hold reset=0 2 cycles, release → count=0, out_valid=0, in_ready=1, out_instr=32'h0, out_pc=0.
- Pass-through: push {3000, 3c010001}, out_ready=1 every cycle.
  - Next cycle out_valid=1, out_pc=32'h3000, out_instr=32'h3c010001.
  - Following cycle empty.
- Fill/backpressure: out_ready=0, push 3000, 3004, 3008.
  - After 2 pushes count=2, in_ready=0; the 3008 push is held.
  - Then out_ready=1 → pops 3000, then 3004 accepted... order seen on out_pc: 3000, 3004, 3008.
- Wrap-around: stream 8 sequential PCs 3000..301c with out_ready toggling 1,0,1,0 → out_pc order exact, no loss or duplication, count never >2.
- Flush: buffer holds 3000, 3004; assert flush with in_valid=1 pc=3008 → next cycle count=0, out_valid=0; 3008 never appears on out_pc.
- Stall counter (with FETCH_BUF_STALL_CNT_EN): full buffer, in_valid=1, out_ready=0 for 5 cycles → stall_cnt=5; flush → stays 5; reset → 0.

Source files
------------

// File: rtl/stage_fetch_buf_pkg.sv
// Shared definitions for the fetch-to-decode skid buffer.
// Holds the datapath widths, the default empty-slot instruction word,
// the reset PC that benches use as a stream origin, and the stored entry type.
package stage_fetch_buf_pkg;

    // Architectural widths of a fetched instruction and its address.
    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    // Instruction word presented to decode when nothing is buffered.
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    // First PC fetched after reset; used to build expected PC streams.
    localparam logic [PC_W-1:0] PC_RESET = 32'h0000_3000;

    // One buffered fetch result.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : stage_fetch_buf_pkg

// File: rtl/fetch_buf_ptr.sv
// Wrapping pointer register for the fetch buffer.
// Counts 0..DEPTH-1 and wraps naturally because DEPTH is a power of two.
// A clear returns the pointer to slot 0 and takes priority over an increment.
module fetch_buf_ptr #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer value: clear wins, otherwise step by one on inc.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples pre-edge values regardless of block order.
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : fetch_buf_ptr

// File: rtl/stage_fetch_buf.sv
// Instruction skid buffer between fetch and decode.
// Captures {pc, instr} pairs from fetch over a valid/ready handshake, holds up
// to DEPTH of them in a circular array, and presents the oldest to decode.
// A flush (control-flow redirect) discards every buffered entry and any push
// in the same cycle. in_ready depends only on the occupancy, never on
// out_ready, so a full buffer refuses a push even while it is being drained.
// Optional feature: define FETCH_BUF_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of cycles where fetch offered an instruction that was
// refused for lack of space.
module stage_fetch_buf
    import stage_fetch_buf_pkg::*;
#(
    parameter int unsigned      DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_BUF_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          push;
    logic          pop;

    // Handshake qualification: a flush suppresses both sides of the transfer.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid  & in_ready  & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Read and write pointers; flush returns both to slot 0.
    fetch_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    fetch_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    // Occupancy next state: push/pop adjust it, flush empties the buffer.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register; reset overrides flush and handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage written at the tail on every accepted push.
    assign wr_entry = '{pc: in_pc, instr: in_instr};

    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; count gating keeps stale slots off the outputs.
        if (push) begin
            mem_q[wr_ptr] <= wr_entry;
        end
    end

    // Head presentation, gated by occupancy so empty slots never leak out.
    always_comb begin
        head      = mem_q[rd_ptr];
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end
    end

    assign count = count_q;

`ifdef FETCH_BUF_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    // Stall counter next state: count refused offers, hold at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule : stage_fetch_buf

// File: tb/tb_stage_fetch_buf.sv
// Self-checking bench for stage_fetch_buf.
// Table of directed single-cycle vectors plus hand-written sequences for
// reset, mid-stream reset, a wrapping stream with toggled back-pressure and,
// when FETCH_BUF_STALL_CNT_EN is defined, the stall counter.
module tb_stage_fetch_buf;
    import stage_fetch_buf_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  count;
`ifdef FETCH_BUF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    stage_fetch_buf #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
`ifdef FETCH_BUF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed cycle: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic [1:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".count"},     32'(count),     32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_pc"},    out_pc,         32'h0);
        check({tag, ".out_instr"}, out_instr,      32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic        prev_ir;
        int          sent;
        int          popped;
        logic [31:0] exp_pc;

        // Pass-through, fill/back-pressure, flush with held and partial contents.
        vecs[0]  = '{1'b0, 1'b1, 32'h3000, 32'h3c01_0001, 1'b1, 2'd1, 1'b1, 1'b1, 32'h3000, 32'h3c01_0001};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h3000, 32'h3c01_0001, 1'b0, 2'd1, 1'b1, 1'b1, 32'h3000, 32'h3c01_0001};
        vecs[3]  = '{1'b0, 1'b1, 32'h3004, 32'h2421_0004, 1'b0, 2'd2, 1'b1, 1'b0, 32'h3000, 32'h3c01_0001};
        vecs[4]  = '{1'b0, 1'b1, 32'h3008, 32'h8c22_0000, 1'b0, 2'd2, 1'b1, 1'b0, 32'h3000, 32'h3c01_0001};
        vecs[5]  = '{1'b0, 1'b1, 32'h3008, 32'h8c22_0000, 1'b1, 2'd1, 1'b1, 1'b1, 32'h3004, 32'h2421_0004};
        vecs[6]  = '{1'b0, 1'b1, 32'h3008, 32'h8c22_0000, 1'b1, 2'd1, 1'b1, 1'b1, 32'h3008, 32'h8c22_0000};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h3000, 32'h3c01_0001, 1'b0, 2'd1, 1'b1, 1'b1, 32'h3000, 32'h3c01_0001};
        vecs[9]  = '{1'b0, 1'b1, 32'h3004, 32'h2421_0004, 1'b0, 2'd2, 1'b1, 1'b0, 32'h3000, 32'h3c01_0001};
        vecs[10] = '{1'b1, 1'b1, 32'h3008, 32'h8c22_0000, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};
        vecs[12] = '{1'b0, 1'b1, 32'h3010, 32'hac23_0008, 1'b0, 2'd1, 1'b1, 1'b1, 32'h3010, 32'hac23_0008};
        vecs[13] = '{1'b1, 1'b1, 32'h3014, 32'h0000_0013, 1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 2'd0, 1'b0, 1'b1, 32'h0,    32'h0};

        // Reset then idle.
        do_reset();
        #1;
        check_empty("reset");

        // Directed table; in_ready before each edge must still reflect the prior state.
        prev_ir = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_instr  = vecs[i].instr;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d.in_ready_pre", i), 32'(in_ready), 32'(prev_ir));
            tick();
            check($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
            check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d.out_pc", i),    out_pc,         vecs[i].e_pc);
            check($sformatf("v%0d.out_instr", i), out_instr,      vecs[i].e_instr);
            prev_ir = vecs[i].e_ir;
        end
        idle_inputs();

        // Wrap-around stream of 8 PCs with out_ready toggling 1,0,1,0.
        sent   = 0;
        popped = 0;
        for (int cyc = 0; cyc < 100 && popped < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_pc     = PC_RESET + 32'(4 * sent);
            in_instr  = 32'hA000_0000 | in_pc;
            out_ready = (cyc % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                exp_pc = PC_RESET + 32'(4 * popped);
                check($sformatf("wrap.pc%0d", popped),    out_pc,    exp_pc);
                check($sformatf("wrap.instr%0d", popped), out_instr, 32'hA000_0000 | exp_pc);
                popped++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            check($sformatf("wrap.count_le2.c%0d", cyc), 32'(count <= 2'd2), 32'd1);
        end
        check("wrap.popped", 32'(popped), 32'd8);
        idle_inputs();
        #1;
        check_empty("wrap.end");

        // Mid-stream reset drops buffered entries and beats a same-cycle push.
        in_valid = 1'b1; in_pc = 32'h3020; in_instr = 32'h1111_1111;
        tick();
        in_pc = 32'h3024; in_instr = 32'h2222_2222;
        tick();
        check("midrst.full", 32'(count), 32'd2);
        in_pc = 32'h3028; flush = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1;
        idle_inputs();
        #1;
        check_empty("midrst");

`ifdef FETCH_BUF_STALL_CNT_EN
        // Stall counter: refused offers counted, flush keeps it, reset clears it.
        do_reset();
        #1;
        check("stall.reset", stall_cnt, 32'd0);
        in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3c01_0001;
        tick();
        in_pc = 32'h3004; in_instr = 32'h2421_0004;
        tick();
        check("stall.fill", stall_cnt, 32'd0);
        in_pc = 32'h3008; in_instr = 32'h8c22_0000;
        for (int i = 0; i < 5; i++) tick();
        check("stall.after5", stall_cnt, 32'd5);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("stall.flush_keeps", stall_cnt, 32'd5);
        check("stall.flush_count", 32'(count), 32'd0);
        do_reset();
        #1;
        check("stall.reset_clears", stall_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stage_fetch_buf
